// File: rtl/adc_acq_wingen_multi.sv
// Multi-echo ADC acquisition window generator: per ACQ_WND rising edge, wait a delay, then enable the ADC for N*M cycles.
// Optional macro ADC_ACQ_TIMEOUT_EN adds a WAIT_WND timeout; without it TIMEOUT is tied low.
module adc_acq_wingen_multi #(
    parameter int DATABUS_WIDTH  = 32,
    parameter int ECHO_WIDTH     = 16,
    parameter int DECIM_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATABUS_WIDTH-1:0] ADC_INIT_DELAY,
    input  logic [DATABUS_WIDTH-1:0] SAMPLES_PER_ECHO,
    input  logic [ECHO_WIDTH-1:0]    ECHOES_PER_SCAN,
    input  logic [DECIM_WIDTH-1:0]   DECIM,
    input  logic                     ARM,
    input  logic                     ABORT,
    input  logic                     ACQ_WND,
    output logic                     ACQ_EN,
    output logic                     SAMPLE_STB,
    output logic [ECHO_WIDTH-1:0]    ECHO_IDX,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     MISSED_WND,
    output logic                     TIMEOUT
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WND,
        DELAY,
        ACQ,
        END_ECHO
    } state_t;

    localparam logic [DATABUS_WIDTH-1:0] ONE_D = DATABUS_WIDTH'(1);
    localparam logic [ECHO_WIDTH-1:0]    ONE_E = ECHO_WIDTH'(1);
    localparam logic [DECIM_WIDTH-1:0]   ONE_M = DECIM_WIDTH'(1);

    state_t state;
    state_t state_next;

    logic sync1;
    logic sync2;
    logic sync_prev;
    logic wnd_edge;

    logic [DATABUS_WIDTH-1:0] lat_delay;
    logic [DATABUS_WIDTH-1:0] lat_samples;
    logic [ECHO_WIDTH-1:0]    lat_echoes;
    logic [DECIM_WIDTH-1:0]   lat_decim;

    logic [DATABUS_WIDTH-1:0] delay_cnt;
    logic [DATABUS_WIDTH-1:0] sample_cnt;
    logic [DECIM_WIDTH-1:0]   decim_cnt;
    logic [ECHO_WIDTH-1:0]    echo_idx;
    logic                     missed;
    logic                     timeout_hit;
    logic                     last_echo;
    logic                     arm_accept;

    // Two-flop synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= ACQ_WND;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign wnd_edge   = sync2 & ~sync_prev;
    assign last_echo  = ({1'b0, echo_idx} + {1'b0, ONE_E}) == {1'b0, lat_echoes};
    assign arm_accept = (state == IDLE) && ARM && !ABORT;

`ifdef ADC_ACQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_flag;

    // Counts cycles spent in WAIT_WND; any exit clears it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == WAIT_WND && state_next == WAIT_WND) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end
            if (arm_accept) begin
                timeout_flag <= 1'b0;
            end else if (state == WAIT_WND && !wnd_edge && timeout_hit && !ABORT) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout_hit = (to_cnt == TO_LAST);
    assign TIMEOUT     = timeout_flag;
`else
    assign timeout_hit = 1'b0;
    assign TIMEOUT     = 1'b0;
`endif

    // Next-state logic; ABORT overrides every transition out of a busy state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ARM) begin
                    state_next = WAIT_WND;
                end
            end
            WAIT_WND: begin
                if (wnd_edge) begin
                    state_next = (lat_delay == ONE_D) ? ACQ : DELAY;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DELAY: begin
                if (delay_cnt == ONE_D) begin
                    state_next = ACQ;
                end
            end
            ACQ: begin
                if (decim_cnt == ONE_M && sample_cnt == ONE_D) begin
                    state_next = END_ECHO;
                end
            end
            END_ECHO: begin
                state_next = last_echo ? IDLE : WAIT_WND;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (ABORT) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Parameter latching, nested sample/decimation countdown and status flags
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lat_delay   <= '0;
            lat_samples <= '0;
            lat_echoes  <= '0;
            lat_decim   <= '0;
            delay_cnt   <= '0;
            sample_cnt  <= '0;
            decim_cnt   <= '0;
            echo_idx    <= '0;
            missed      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm_accept) begin
                        lat_delay   <= (ADC_INIT_DELAY == '0)   ? ONE_D : ADC_INIT_DELAY;
                        lat_samples <= (SAMPLES_PER_ECHO == '0) ? ONE_D : SAMPLES_PER_ECHO;
                        lat_echoes  <= (ECHOES_PER_SCAN == '0)  ? ONE_E : ECHOES_PER_SCAN;
                        lat_decim   <= (DECIM == '0)            ? ONE_M : DECIM;
                        echo_idx    <= '0;
                        missed      <= 1'b0;
                    end
                end
                WAIT_WND: begin
                    if (wnd_edge) begin
                        delay_cnt  <= lat_delay - ONE_D;
                        sample_cnt <= lat_samples;
                        decim_cnt  <= lat_decim;
                    end
                end
                DELAY: begin
                    if (delay_cnt != ONE_D) begin
                        delay_cnt <= delay_cnt - ONE_D;
                    end
                end
                ACQ: begin
                    if (decim_cnt == ONE_M) begin
                        if (sample_cnt != ONE_D) begin
                            sample_cnt <= sample_cnt - ONE_D;
                            decim_cnt  <= lat_decim;
                        end
                    end else begin
                        decim_cnt <= decim_cnt - ONE_M;
                    end
                end
                END_ECHO: begin
                    if (!last_echo && !ABORT) begin
                        echo_idx <= echo_idx + ONE_E;
                    end
                end
                default: begin
                end
            endcase
            if (wnd_edge && (state == DELAY || state == ACQ || state == END_ECHO)) begin
                missed <= 1'b1;
            end
        end
    end

    assign ACQ_EN     = (state == ACQ);
    assign SAMPLE_STB = (state == ACQ) && (decim_cnt == ONE_M);
    assign DONE       = (state == END_ECHO) && last_echo && !ABORT;
    assign BUSY       = (state != IDLE);
    assign ECHO_IDX   = echo_idx;
    assign MISSED_WND = missed;

endmodule

// File: tb/tb_adc_acq_wingen_multi.sv
// Scoreboard bench for adc_acq_wingen_multi: each driven window pushes its expected ACQ_EN run,
// and a negedge monitor pops and compares every observed run.
module tb_adc_acq_wingen_multi;

    localparam int DW = 32;
    localparam int EW = 16;
    localparam int MW = 8;
    localparam int TO = 100;
`ifdef ADC_ACQ_TIMEOUT_EN
    localparam int WND_HOLD = 60;
`else
    localparam int WND_HOLD = 200;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic [DW-1:0] ADC_INIT_DELAY;
    logic [DW-1:0] SAMPLES_PER_ECHO;
    logic [EW-1:0] ECHOES_PER_SCAN;
    logic [MW-1:0] DECIM;
    logic          ARM;
    logic          ABORT;
    logic          ACQ_WND;
    logic          ACQ_EN;
    logic          SAMPLE_STB;
    logic [EW-1:0] ECHO_IDX;
    logic          BUSY;
    logic          DONE;
    logic          MISSED_WND;
    logic          TIMEOUT;

    adc_acq_wingen_multi #(
        .DATABUS_WIDTH (DW),
        .ECHO_WIDTH    (EW),
        .DECIM_WIDTH   (MW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .ADC_INIT_DELAY  (ADC_INIT_DELAY),
        .SAMPLES_PER_ECHO(SAMPLES_PER_ECHO),
        .ECHOES_PER_SCAN (ECHOES_PER_SCAN),
        .DECIM           (DECIM),
        .ARM             (ARM),
        .ABORT           (ABORT),
        .ACQ_WND         (ACQ_WND),
        .ACQ_EN          (ACQ_EN),
        .SAMPLE_STB      (SAMPLE_STB),
        .ECHO_IDX        (ECHO_IDX),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .MISSED_WND      (MISSED_WND),
        .TIMEOUT         (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int start;
        int len;
        int strobes;
        int idx;
        bit done;
        int decim;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   done_count = 0;

    bit   in_run = 1'b0;
    int   run_start;
    int   run_len;
    int   run_stb;
    int   run_err;
    int   run_idx;
    int   run_m;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic finishRun();
        exp_t e;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_window", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            checkOutput("win_start", run_start, e.start);
            checkOutput("win_len", run_len, e.len);
            checkOutput("win_strobes", run_stb, e.strobes);
            checkOutput("win_strobe_pos_idx", run_err, 0);
            checkOutput("win_echo_idx", run_idx, e.idx);
            checkOutput("win_done", DONE, e.done);
        end
    endtask

    // Records each contiguous ACQ_EN run and scores it when it ends
    always @(negedge CLK) begin
        if (RESET !== 1'b0) begin
            in_run = 1'b0;
        end else begin
            if (DONE === 1'b1) done_count++;
            if (ACQ_EN === 1'b1) begin
                if (!in_run) begin
                    in_run    = 1'b1;
                    run_start = cyc;
                    run_len   = 0;
                    run_stb   = 0;
                    run_err   = 0;
                    run_idx   = int'(ECHO_IDX);
                    run_m     = (exp_q.size() > 0) ? exp_q[0].decim : 1;
                end
                run_len++;
                if (SAMPLE_STB === 1'b1) run_stb++;
                if ((SAMPLE_STB === 1'b1) != ((run_len % run_m) == 0)) run_err++;
                if (int'(ECHO_IDX) != run_idx) run_err++;
            end else if (in_run) begin
                in_run = 1'b0;
                finishRun();
            end
        end
    end

    task automatic applyStimulus(input int d, input int n, input int e, input int m);
        @(negedge CLK);
        ADC_INIT_DELAY   = DW'(d);
        SAMPLES_PER_ECHO = DW'(n);
        ECHOES_PER_SCAN  = EW'(e);
        DECIM            = MW'(m);
        ARM              = 1'b1;
        @(negedge CLK);
        ARM = 1'b0;
        checkOutput("arm_busy", BUSY, 1);
        checkOutput("arm_missed_clr", MISSED_WND, 0);
        checkOutput("arm_timeout_clr", TIMEOUT, 0);
        checkOutput("arm_idx_clr", ECHO_IDX, 0);
    endtask

    function automatic void pushExp(input int t, input int d, input int n, input int m,
                                    input int idx, input bit done);
        exp_q.push_back('{start: t + d, len: n * m, strobes: n, idx: idx, done: done, decim: m});
    endfunction

    // Caller is at a negedge; edge is detected two cycles after the raise
    task automatic raiseWindow(input int hold, input int gap, input int d, input int n,
                               input int m, input int idx, input bit done, output int t);
        ACQ_WND = 1'b1;
        t = cyc + 2;
        pushExp(t, d, n, m, idx, done);
        repeat (hold) @(negedge CLK);
        ACQ_WND = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    initial begin
        int t;
        int d0;
        int a;
        RESET            = 1'b1;
        ADC_INIT_DELAY   = '0;
        SAMPLES_PER_ECHO = '0;
        ECHOES_PER_SCAN  = '0;
        DECIM            = '0;
        ARM              = 1'b0;
        ABORT            = 1'b0;
        ACQ_WND          = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_acq_en", ACQ_EN, 0);
        checkOutput("rst_stb", SAMPLE_STB, 0);
        checkOutput("rst_idx", ECHO_IDX, 0);
        checkOutput("rst_busy", BUSY, 0);
        checkOutput("rst_done", DONE, 0);
        checkOutput("rst_missed", MISSED_WND, 0);
        checkOutput("rst_timeout", TIMEOUT, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // ABORT together with ARM in IDLE keeps the block idle
        ARM   = 1'b1;
        ABORT = 1'b1;
        @(negedge CLK);
        ARM   = 1'b0;
        ABORT = 1'b0;
        checkOutput("arm_abort_idle", BUSY, 0);

        // Single echo, D=3 N=4 M=1
        d0 = done_count;
        applyStimulus(3, 4, 1, 1);
        raiseWindow(3, 0, 3, 4, 1, 0, 1'b1, t);
        waitUntil(t + 7);
        checkOutput("t1_busy_at_done", BUSY, 1);
        checkOutput("t1_done_cycle", DONE, 1);
        @(negedge CLK);
        checkOutput("t1_busy_low", BUSY, 0);
        checkOutput("t1_done_count", done_count - d0, 1);

        // Decimated: D=5 N=3 M=4
        d0 = done_count;
        applyStimulus(5, 3, 1, 4);
        raiseWindow(5, 0, 5, 3, 4, 0, 1'b1, t);
        waitUntil(t + 5 + 12 + 2);
        checkOutput("t2_busy_low", BUSY, 0);
        checkOutput("t2_done_count", done_count - d0, 1);

        // Three echoes with long windows; no retrigger while held high
        d0 = done_count;
        applyStimulus(2, 10, 3, 1);
        for (int i = 0; i < 3; i++) begin
            raiseWindow(WND_HOLD, 20, 2, 10, 1, i, (i == 2), t);
        end
        checkOutput("t3_busy_low", BUSY, 0);
        checkOutput("t3_done_count", done_count - d0, 1);
        checkOutput("t3_idx_final", ECHO_IDX, 2);
        checkOutput("t3_missed", MISSED_WND, 0);

        // Extra edge during ACQ is counted as missed
        d0 = done_count;
        applyStimulus(2, 50, 1, 1);
        raiseWindow(10, 10, 2, 50, 1, 0, 1'b1, t);
        ACQ_WND = 1'b1;
        repeat (10) @(negedge CLK);
        ACQ_WND = 1'b0;
        waitUntil(t + 55);
        checkOutput("t4_missed", MISSED_WND, 1);
        checkOutput("t4_idx", ECHO_IDX, 0);
        checkOutput("t4_busy_low", BUSY, 0);
        checkOutput("t4_done_count", done_count - d0, 1);
        applyStimulus(1, 1, 1, 1);
        @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        checkOutput("t4_abort_wait_busy", BUSY, 0);

        // All-zero parameters clamp to one cycle
        d0 = done_count;
        applyStimulus(0, 0, 0, 0);
        raiseWindow(3, 5, 1, 1, 1, 0, 1'b1, t);
        waitUntil(t + 4);
        checkOutput("t5_busy_low", BUSY, 0);
        checkOutput("t5_done_count", done_count - d0, 1);

        // ABORT mid-ACQ truncates the window, no DONE
        d0 = done_count;
        applyStimulus(2, 50, 1, 1);
        ACQ_WND = 1'b1;
        t = cyc + 2;
        exp_q.push_back('{start: t + 2, len: 10, strobes: 10, idx: 0, done: 1'b0, decim: 1});
        waitUntil(t + 11);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        checkOutput("t5_abort_acq_en", ACQ_EN, 0);
        checkOutput("t5_abort_busy", BUSY, 0);
        ACQ_WND = 1'b0;
        repeat (5) @(negedge CLK);
        checkOutput("t5_abort_no_done", done_count - d0, 0);

        // Async reset during DELAY after a missed edge
        applyStimulus(20, 5, 2, 1);
        ACQ_WND = 1'b1;
        t = cyc + 2;
        repeat (3) @(negedge CLK);
        ACQ_WND = 1'b0;
        repeat (3) @(negedge CLK);
        ACQ_WND = 1'b1;
        waitUntil(t + 12);
        checkOutput("t6_busy_delay", BUSY, 1);
        checkOutput("t6_missed_set", MISSED_WND, 1);
        #2 RESET = 1'b1;
        #1;
        checkOutput("t6_rst_busy", BUSY, 0);
        checkOutput("t6_rst_missed", MISSED_WND, 0);
        checkOutput("t6_rst_acq_en", ACQ_EN, 0);
        checkOutput("t6_rst_idx", ECHO_IDX, 0);
        ACQ_WND = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        // WAIT_WND with no window edge
        d0 = done_count;
        applyStimulus(1, 1, 1, 1);
        a = cyc - 1;
`ifdef ADC_ACQ_TIMEOUT_EN
        waitUntil(a + TO);
        checkOutput("to_busy_before", BUSY, 1);
        checkOutput("to_flag_before", TIMEOUT, 0);
        @(negedge CLK);
        checkOutput("to_busy_after", BUSY, 0);
        checkOutput("to_flag_after", TIMEOUT, 1);
`else
        waitUntil(a + TO + 50);
        checkOutput("wait_forever_busy", BUSY, 1);
        checkOutput("wait_timeout_tied", TIMEOUT, 0);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        checkOutput("wait_abort_busy", BUSY, 0);
`endif
        checkOutput("to_no_done", done_count - d0, 0);

        repeat (5) @(negedge CLK);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("no_open_window", in_run, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
